// File: rtl/calc_entry_ctrl.sv
// Operand-entry and compute controller: three push-buttons step the user through entering
// A and B one hex digit at a time, then one compute cycle produces the result for the display mux.
`timescale 1ns/1ps
module calc_entry_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       digit_in,
   input  logic             key_digit_n,
   input  logic             key_enter_n,
   input  logic             key_clear_n,
   input  logic [1:0]       op_sel,
   output logic [WIDTH-1:0] reg_A,
   output logic [WIDTH-1:0] reg_B,
   output logic [WIDTH-1:0] reg_result,
   output logic [1:0]       display_select,
   output logic             overflow
);

   typedef enum logic [1:0] {StEnterA, StEnterB, StCompute, StShow} state_e;

   state_e     state;
   logic [1:0] op_q;

   // Key order in the vectors below: {clear, enter, digit}
   logic [2:0] key_meta;
   logic [2:0] key_sync;
   logic [2:0] key_prev;
   logic [2:0] key_fall;
   logic       clear_ev;
   logic       enter_ev;
   logic       digit_ev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_meta <= 3'b111;
         key_sync <= 3'b111;
         key_prev <= 3'b111;
      end else begin
         key_meta <= {key_clear_n, key_enter_n, key_digit_n};
         key_sync <= key_meta;
         key_prev <= key_sync;
      end
   end

   assign key_fall = key_prev & ~key_sync;
   assign clear_ev = key_fall[2];
   assign enter_ev = key_fall[1] & ~key_fall[2];
   assign digit_ev = key_fall[0] & ~key_fall[1] & ~key_fall[2];

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                 input logic [3:0] d);
      return (r << 4) | WIDTH'(d);
   endfunction

   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_ovf;

   always_comb begin
      sum     = {1'b0, reg_A} + {1'b0, reg_B};
      diff    = {1'b0, reg_A} - {1'b0, reg_B};
      prod    = {{WIDTH{1'b0}}, reg_A} * {{WIDTH{1'b0}}, reg_B};
      alu_res = '0;
      alu_ovf = 1'b0;
      unique case (op_q)
         2'b00: begin
            alu_res = sum[WIDTH-1:0];
            alu_ovf = sum[WIDTH];
         end
         2'b01: begin
            // Borrow out of the extended subtraction is exactly A < B
            alu_res = diff[WIDTH-1:0];
            alu_ovf = diff[WIDTH];
         end
         2'b10: begin
            alu_res = prod[WIDTH-1:0];
            alu_ovf = |prod[2*WIDTH-1:WIDTH];
         end
         default: begin
            alu_res = reg_A ^ reg_B;
            alu_ovf = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= StEnterA;
         op_q           <= 2'b00;
         reg_A          <= '0;
         reg_B          <= '0;
         reg_result     <= '0;
         overflow       <= 1'b0;
         display_select <= 2'b00;
      end else if (clear_ev) begin
         state          <= StEnterA;
         reg_A          <= '0;
         reg_B          <= '0;
         reg_result     <= '0;
         overflow       <= 1'b0;
         display_select <= 2'b00;
      end else begin
         unique case (state)
            StEnterA: begin
               if (enter_ev) begin
                  reg_B          <= '0;
                  state          <= StEnterB;
                  display_select <= 2'b01;
               end else if (digit_ev) begin
                  reg_A <= shift_in(reg_A, digit_in);
               end
            end
            StEnterB: begin
               if (enter_ev) begin
                  op_q           <= op_sel;
                  state          <= StCompute;
                  display_select <= 2'b01;
               end else if (digit_ev) begin
                  reg_B <= shift_in(reg_B, digit_in);
               end
            end
            StCompute: begin
               reg_result     <= alu_res;
               overflow       <= alu_ovf;
               state          <= StShow;
               display_select <= 2'b10;
            end
            StShow: begin
               if (enter_ev) begin
                  reg_A          <= reg_result;
                  reg_B          <= '0;
                  state          <= StEnterB;
                  display_select <= 2'b01;
               end else if (digit_ev) begin
                  reg_A          <= shift_in('0, digit_in);
                  reg_B          <= '0;
                  overflow       <= 1'b0;
                  state          <= StEnterA;
                  display_select <= 2'b00;
               end
            end
            default: begin
               state          <= StEnterA;
               display_select <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed vector table, hand-written timing/corner sequences,
// and random key presses checked against an arithmetic model of the calculator.
`timescale 1ns/1ps
module tb_calc_entry_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [3:0]  digit_in = 4'h0;
   logic        key_digit_n = 1'b1;
   logic        key_enter_n = 1'b1;
   logic        key_clear_n = 1'b1;
   logic [1:0]  op_sel = 2'b00;
   logic [31:0] reg_A;
   logic [31:0] reg_B;
   logic [31:0] reg_result;
   logic [1:0]  display_select;
   logic        overflow;

   int checks = 0;
   int failures = 0;

   localparam int KDigit = 0;
   localparam int KEnter = 1;
   localparam int KClear = 2;

   calc_entry_ctrl #(.WIDTH(32)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .digit_in       (digit_in),
      .key_digit_n    (key_digit_n),
      .key_enter_n    (key_enter_n),
      .key_clear_n    (key_clear_n),
      .op_sel         (op_sel),
      .reg_A          (reg_A),
      .reg_B          (reg_B),
      .reg_result     (reg_result),
      .display_select (display_select),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [3:0]  dig;
      logic [1:0]  op;
      int          rep;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [31:0] er;
      logic        eo;
      logic [1:0]  ed;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input int kind, input logic [3:0] dig, input logic [1:0] op,
                          input int rep, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] er, input logic eo, input logic [1:0] ed,
                          input string name);
      vec_t v;
      v.kind = kind; v.dig = dig; v.op = op; v.rep = rep;
      v.ea = ea; v.eb = eb; v.er = er; v.eo = eo; v.ed = ed; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic o, input logic [1:0] d);
      checks++;
      if (reg_A !== a || reg_B !== b || reg_result !== r || overflow !== o ||
          display_select !== d) begin
         failures++;
         $display("FAIL %s: got A=%h B=%h R=%h ovf=%b disp=%b, want A=%h B=%h R=%h ovf=%b disp=%b",
                  name, reg_A, reg_B, reg_result, overflow, display_select, a, b, r, o, d);
      end
   endtask

   task automatic set_key(input int kind, input logic v);
      case (kind)
         KDigit:  key_digit_n = v;
         KEnter:  key_enter_n = v;
         default: key_clear_n = v;
      endcase
   endtask

   // Full press/release; starts and ends 1 ns after a rising edge.
   task automatic press(input int kind, input logic [3:0] d, input logic [1:0] op);
      digit_in = d;
      op_sel   = op;
      set_key(kind, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      op_sel = 2'($urandom_range(0, 3));
      set_key(kind, 1'b1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Reference model
   int          m_state;  // 0 entering A, 1 entering B, 2 showing result
   logic [31:0] ma, mb, mr;
   logic        mo;

   function automatic logic [1:0] m_disp();
      return (m_state == 0) ? 2'b00 : (m_state == 1) ? 2'b01 : 2'b10;
   endfunction

   task automatic m_event(input int kind, input logic [3:0] d, input logic [1:0] op);
      logic [63:0] wide;
      if (kind == KClear) begin
         ma = 0; mb = 0; mr = 0; mo = 0; m_state = 0;
      end else if (kind == KEnter) begin
         if (m_state == 0) begin
            mb = 0; m_state = 1;
         end else if (m_state == 1) begin
            case (op)
               2'd0: begin
                  wide = 64'(ma) + 64'(mb);
                  mr = wide[31:0]; mo = (wide >= 64'h1_0000_0000);
               end
               2'd1: begin
                  mr = ma - mb; mo = (ma < mb);
               end
               2'd2: begin
                  wide = 64'(ma) * 64'(mb);
                  mr = wide[31:0]; mo = (wide >= 64'h1_0000_0000);
               end
               default: begin
                  mr = ma ^ mb; mo = 1'b0;
               end
            endcase
            m_state = 2;
         end else begin
            ma = mr; mb = 0; m_state = 1;
         end
      end else begin
         if (m_state == 0) ma = ma * 16 + 32'(d);
         else if (m_state == 1) mb = mb * 16 + 32'(d);
         else begin
            ma = 32'(d); mb = 0; mo = 0; m_state = 0;
         end
      end
   endtask

   logic [31:0] wrap_exp [9];

   initial begin
      wrap_exp = '{32'h1, 32'h12, 32'h123, 32'h1234, 32'h12345, 32'h123456, 32'h1234567,
                   32'h12345678, 32'h23456789};

      // Reset state
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 0, 0, 0, 0, 2'b00);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-entry aborts, then entry resumes from zero
      press(KDigit, 4'h1, 2'b00);
      press(KDigit, 4'h2, 2'b00);
      check("pre_reset_entry", 32'h12, 0, 0, 0, 2'b00);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset", 0, 0, 0, 0, 2'b00);
      @(posedge clk);
      #4 reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("after_reset", 0, 0, 0, 0, 2'b00);
      press(KDigit, 4'h5, 2'b00);
      check("digit_after_reset", 32'h5, 0, 0, 0, 2'b00);

      // Reset during COMPUTE gives no partial result
      press(KEnter, 4'h0, 2'b00);
      press(KDigit, 4'h3, 2'b00);
      op_sel = 2'b00;
      key_enter_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("in_compute", 32'h5, 32'h3, 0, 0, 2'b01);
      reset_n = 1'b0;
      #2 key_enter_n = 1'b1;
      #2 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("reset_in_compute", 0, 0, 0, 0, 2'b00);

      // Compute latency: event, COMPUTE, then SHOW
      press(KDigit, 4'h1, 2'b00);
      press(KDigit, 4'h2, 2'b00);
      press(KEnter, 4'h0, 2'b00);
      press(KDigit, 4'h3, 2'b00);
      press(KDigit, 4'h4, 2'b00);
      op_sel = 2'b00;
      key_enter_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("event_cycle", 32'h12, 32'h34, 0, 0, 2'b01);
      @(posedge clk);
      #1;
      check("compute_cycle", 32'h12, 32'h34, 0, 0, 2'b01);
      @(posedge clk);
      #1;
      check("add_show", 32'h12, 32'h34, 32'h46, 0, 2'b10);
      key_enter_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // op_sel changes in SHOW must not touch the result
      op_sel = 2'b10;
      repeat (10) @(posedge clk);
      #1;
      check("op_change_in_show", 32'h12, 32'h34, 32'h46, 0, 2'b10);

      // Clear and enter together: clear wins, enter dropped
      key_clear_n = 1'b0;
      key_enter_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("clear_beats_enter", 0, 0, 0, 0, 2'b00);
      key_clear_n = 1'b1;
      key_enter_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("clear_beats_enter_settled", 0, 0, 0, 0, 2'b00);

      // Held key gives a single event
      digit_in = 4'h9;
      key_digit_n = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("held_digit", 32'h9, 0, 0, 0, 2'b00);
      key_digit_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Directed vector table
      add_vec(KClear, 4'h0, 2'd0, 1, 0, 0, 0, 0, 2'b00, "clear0");
      add_vec(KDigit, 4'h1, 2'd0, 1, 32'h1, 0, 0, 0, 2'b00, "a_d1");
      add_vec(KDigit, 4'h2, 2'd0, 1, 32'h12, 0, 0, 0, 2'b00, "a_d2");
      add_vec(KEnter, 4'h0, 2'd0, 1, 32'h12, 0, 0, 0, 2'b01, "to_b");
      add_vec(KDigit, 4'h3, 2'd0, 1, 32'h12, 32'h3, 0, 0, 2'b01, "b_d3");
      add_vec(KDigit, 4'h4, 2'd0, 1, 32'h12, 32'h34, 0, 0, 2'b01, "b_d4");
      add_vec(KEnter, 4'h0, 2'd0, 1, 32'h12, 32'h34, 32'h46, 0, 2'b10, "add");
      add_vec(KEnter, 4'h0, 2'd3, 1, 32'h46, 0, 32'h46, 0, 2'b01, "chain");
      add_vec(KClear, 4'h0, 2'd0, 1, 0, 0, 0, 0, 2'b00, "clear1");
      for (int i = 0; i < 9; i++)
         add_vec(KDigit, 4'(i + 1), 2'd0, 1, wrap_exp[i], 0, 0, 0, 2'b00,
                 $sformatf("wrap%0d", i + 1));
      add_vec(KClear, 4'h0, 2'd0, 1, 0, 0, 0, 0, 2'b00, "clear2");
      add_vec(KDigit, 4'hF, 2'd0, 8, 32'hFFFFFFFF, 0, 0, 0, 2'b00, "a_all_f");
      add_vec(KEnter, 4'h0, 2'd0, 1, 32'hFFFFFFFF, 0, 0, 0, 2'b01, "to_b2");
      add_vec(KDigit, 4'h1, 2'd0, 1, 32'hFFFFFFFF, 32'h1, 0, 0, 2'b01, "b_1");
      add_vec(KEnter, 4'h0, 2'd0, 1, 32'hFFFFFFFF, 32'h1, 0, 1, 2'b10, "add_carry");
      add_vec(KDigit, 4'h3, 2'd0, 1, 32'h3, 0, 0, 0, 2'b00, "fresh_3");
      add_vec(KEnter, 4'h0, 2'd0, 1, 32'h3, 0, 0, 0, 2'b01, "to_b3");
      add_vec(KDigit, 4'h5, 2'd0, 1, 32'h3, 32'h5, 0, 0, 2'b01, "b_5");
      add_vec(KEnter, 4'h0, 2'd1, 1, 32'h3, 32'h5, 32'hFFFFFFFE, 1, 2'b10, "sub_borrow");
      add_vec(KDigit, 4'h7, 2'd0, 1, 32'h7, 0, 32'hFFFFFFFE, 0, 2'b00, "fresh_7");
      add_vec(KClear, 4'h0, 2'd0, 1, 0, 0, 0, 0, 2'b00, "clear3");
      add_vec(KDigit, 4'h1, 2'd0, 1, 32'h1, 0, 0, 0, 2'b00, "a_1");
      add_vec(KDigit, 4'h0, 2'd0, 4, 32'h10000, 0, 0, 0, 2'b00, "a_10000");
      add_vec(KEnter, 4'h0, 2'd0, 1, 32'h10000, 0, 0, 0, 2'b01, "to_b4");
      add_vec(KDigit, 4'h1, 2'd0, 1, 32'h10000, 32'h1, 0, 0, 2'b01, "b_1b");
      add_vec(KDigit, 4'h0, 2'd0, 4, 32'h10000, 32'h10000, 0, 0, 2'b01, "b_10000");
      add_vec(KEnter, 4'h0, 2'd2, 1, 32'h10000, 32'h10000, 0, 1, 2'b10, "mul_ovf");
      add_vec(KDigit, 4'h5, 2'd0, 1, 32'h5, 0, 0, 0, 2'b00, "fresh_5");
      add_vec(KEnter, 4'h0, 2'd0, 1, 32'h5, 0, 0, 0, 2'b01, "to_b5");
      add_vec(KDigit, 4'h3, 2'd0, 1, 32'h5, 32'h3, 0, 0, 2'b01, "b_3");
      add_vec(KEnter, 4'h0, 2'd3, 1, 32'h5, 32'h3, 32'h6, 0, 2'b10, "xor");
      add_vec(KEnter, 4'h0, 2'd0, 1, 32'h6, 0, 32'h6, 0, 2'b01, "chain2");
      add_vec(KDigit, 4'h7, 2'd0, 1, 32'h6, 32'h7, 32'h6, 0, 2'b01, "b_7");
      add_vec(KEnter, 4'h0, 2'd2, 1, 32'h6, 32'h7, 32'h2A, 0, 2'b10, "mul");

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].rep; r++) press(vecs[i].kind, vecs[i].dig, vecs[i].op);
         check(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].er, vecs[i].eo, vecs[i].ed);
      end

      // Random key presses against the model
      press(KClear, 4'h0, 2'b00);
      m_event(KClear, 4'h0, 2'b00);
      for (int i = 0; i < 300; i++) begin
         int          sel;
         int          kind;
         logic [3:0]  d;
         logic [1:0]  op;
         sel  = $urandom_range(0, 99);
         kind = (sel < 8) ? KClear : (sel < 40) ? KEnter : KDigit;
         d    = 4'($urandom_range(0, 15));
         op   = 2'($urandom_range(0, 3));
         press(kind, d, op);
         m_event(kind, d, op);
         check($sformatf("rand%0d", i), ma, mb, mr, mo, m_disp());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
